// File: rtl/rv32i_defines.sv
// Shared RV32I memory-access constants: load/store funct3 encodings, MMIO offsets,
// and small decode helpers used by the controller.
package rv32i_defines;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  localparam logic [27:0] MMIO_LEDS   = 28'h000_0000;
  localparam logic [27:0] MMIO_CYCLES = 28'h000_0004;

  function automatic logic funct3_illegal(input logic [2:0] f3, input logic is_store);
    logic bad;
    bad = 1'b1;
    case (f3)
      FUNCT3_LB, FUNCT3_LH, FUNCT3_LW: bad = 1'b0;
      FUNCT3_LBU, FUNCT3_LHU:          bad = is_store;
      default:                         bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    case (f3)
      FUNCT3_LH, FUNCT3_LHU: mis = offset[0];
      FUNCT3_LW:             mis = (offset != 2'b00);
      default:               mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_byte_ena(input logic [2:0] f3, input logic [1:0] offset);
    logic [3:0] be;
    be = 4'b1111;
    case (f3)
      FUNCT3_SB: be = 4'b0001 << offset;
      FUNCT3_SH: be = 4'b0011 << offset;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data is replicated into every lane so the byte enables alone pick the target.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] lanes;
    lanes = data;
    case (f3)
      FUNCT3_SB: lanes = {4{data[7:0]}};
      FUNCT3_SH: lanes = {2{data[15:0]}};
      default:   lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// Combinational load extraction: picks the byte/halfword addressed by offset
// out of a 32-bit word and sign- or zero-extends it according to funct3.
module rv32i_load_align
  import rv32i_defines::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[7:0];
    case (offset)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
  end

  assign sel_half = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (funct3)
      FUNCT3_LB:  data = {{24{sel_byte[7]}}, sel_byte};
      FUNCT3_LH:  data = {{16{sel_half[15]}}, sel_half};
      FUNCT3_LBU: data = {24'h0, sel_byte};
      FUNCT3_LHU: data = {16'h0, sel_half};
      default:    data = word;
    endcase
  end

endmodule

// File: rtl/rv32i_mem_ctrl.sv
// RV32I data-memory controller: one outstanding load/store to a synchronous RAM
// or to a small MMIO block (LED register and free-running cycle counter).
module rv32i_mem_ctrl
  import rv32i_defines::*;
#(
  parameter int          ADDR_W     = 10,
  parameter int          RD_LATENCY = 1,
  parameter logic [31:0] MMIO_BASE  = 32'hF000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [2:0]        funct3,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wr_data,
  output logic [3:0]        ram_byte_ena,
  output logic              ram_wr_ena,
  input  logic [31:0]       ram_rd_data,
  output logic [31:0]       leds
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_t      state;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  funct3_reg;
  logic        we_reg;
  logic [2:0]  wait_cnt;
  logic [31:0] cycles;

  logic        req_mmio;
  logic        req_bad;
  logic        cur_mmio;
  logic [27:0] mmio_off;
  logic [31:0] mmio_word;
  logic [31:0] align_word;
  logic [31:0] load_data;

  // Narrow stores are rejected anywhere in MMIO space, not just at the LED register.
  assign req_mmio = (addr[31:28] == MMIO_BASE[31:28]);
  assign req_bad  = funct3_illegal(funct3, we) || misaligned(funct3, addr[1:0]) ||
                    (req_mmio && we && (funct3 != FUNCT3_SW));

  assign cur_mmio = (addr_reg[31:28] == MMIO_BASE[31:28]);
  assign mmio_off = {addr_reg[27:2], 2'b00};
  assign ram_addr = addr_reg[ADDR_W+1:2];

  always_comb begin
    mmio_word = 32'h0;
    case (mmio_off)
      MMIO_LEDS:   mmio_word = leds;
      MMIO_CYCLES: mmio_word = cycles;
      default:     mmio_word = 32'h0;
    endcase
  end

  assign align_word = cur_mmio ? mmio_word : ram_rd_data;

  rv32i_load_align u_load_align (
    .word   (align_word),
    .offset (addr_reg[1:0]),
    .funct3 (funct3_reg),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles <= 32'h0;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      addr_reg     <= 32'h0;
      wdata_reg    <= 32'h0;
      funct3_reg   <= 3'b000;
      we_reg       <= 1'b0;
      wait_cnt     <= 3'd0;
      ready        <= 1'b0;
      err          <= 1'b0;
      rdata        <= 32'h0;
      leds         <= 32'h0;
      ram_wr_ena   <= 1'b0;
      ram_byte_ena <= 4'b0000;
      ram_wr_data  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          if (req) begin
            addr_reg   <= addr;
            wdata_reg  <= wdata;
            funct3_reg <= funct3;
            we_reg     <= we;
            if (req_bad) begin
              state <= S_DONE;
              ready <= 1'b1;
              err   <= 1'b1;
              rdata <= 32'h0;
            end else begin
              state <= S_ACCESS;
              // Write strobe is registered here so it is high for exactly the ACCESS cycle.
              if (we && !req_mmio) begin
                ram_wr_ena   <= 1'b1;
                ram_byte_ena <= store_byte_ena(funct3, addr[1:0]);
                ram_wr_data  <= store_lanes(funct3, wdata);
              end
            end
          end
        end

        S_ACCESS: begin
          ram_wr_ena   <= 1'b0;
          ram_byte_ena <= 4'b0000;
          if (cur_mmio) begin
            if (we_reg) begin
              if (mmio_off == MMIO_LEDS) begin
                leds <= wdata_reg;
              end
            end else begin
              rdata <= load_data;
            end
            state <= S_DONE;
            ready <= 1'b1;
          end else if (we_reg) begin
            state <= S_DONE;
            ready <= 1'b1;
          end else begin
            state    <= S_WAIT;
            wait_cnt <= 3'd1;
          end
        end

        S_WAIT: begin
          // wait_cnt counts edges since the RAM first saw the address.
          if (wait_cnt == LAT) begin
            rdata <= load_data;
            state <= S_DONE;
            ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end

        S_DONE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_ctrl.sv
// Directed bench for rv32i_mem_ctrl: two builds (RD_LATENCY 1 and 3), each with a
// behavioural synchronous RAM; expected results are queued per access and checked on ready.
module tb_rv32i_mem_ctrl;
  import rv32i_defines::*;

  logic        clk;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic        req_v          [2];
  logic [31:0] rdata_v        [2];
  logic        ready_v        [2];
  logic        err_v          [2];
  logic [9:0]  ram_addr_v     [2];
  logic [31:0] ram_wr_data_v  [2];
  logic [3:0]  ram_byte_ena_v [2];
  logic        ram_wr_ena_v   [2];
  logic [31:0] ram_rd_data_v  [2];
  logic [31:0] leds_v         [2];

  int          tests;
  int          fails;
  int          wr_cnt  [2];
  logic [3:0]  last_be [2];
  logic [9:0]  last_wa [2];
  logic [31:0] last_wd [2];

  typedef struct {
    logic [31:0] exp_rdata;
    logic        check_rdata;
    logic        exp_err;
    int          exp_lat;
  } exp_t;

  exp_t sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;
    logic [31:0] mem  [0:1023];
    logic [31:0] pipe [0:LAT-1];

    rv32i_mem_ctrl #(
      .ADDR_W     (10),
      .RD_LATENCY (LAT),
      .MMIO_BASE  (32'hF000_0000)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req_v[gi]),
      .we           (we),
      .addr         (addr),
      .wdata        (wdata),
      .funct3       (funct3),
      .rdata        (rdata_v[gi]),
      .ready        (ready_v[gi]),
      .err          (err_v[gi]),
      .ram_addr     (ram_addr_v[gi]),
      .ram_wr_data  (ram_wr_data_v[gi]),
      .ram_byte_ena (ram_byte_ena_v[gi]),
      .ram_wr_ena   (ram_wr_ena_v[gi]),
      .ram_rd_data  (ram_rd_data_v[gi]),
      .leds         (leds_v[gi])
    );

    always @(posedge clk) begin
      if (ram_wr_ena_v[gi]) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_byte_ena_v[gi][b]) mem[ram_addr_v[gi]][b*8 +: 8] <= ram_wr_data_v[gi][b*8 +: 8];
        end
      end
      pipe[0] <= mem[ram_addr_v[gi]];
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end

    assign ram_rd_data_v[gi] = pipe[LAT-1];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_wr_ena_v[i] === 1'b1) begin
        wr_cnt[i]  <= wr_cnt[i] + 1;
        last_be[i] <= ram_byte_ena_v[i];
        last_wa[i] <= ram_addr_v[i];
        last_wd[i] <= ram_wr_data_v[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic access(input int sel, input string tag, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic chk_rd, input logic exp_err, input int exp_lat,
                        output logic [31:0] got_rd);
    exp_t e;
    int   lat;
    logic seen;
    sb_q.push_back('{exp_rdata: exp_rd, check_rdata: chk_rd, exp_err: exp_err, exp_lat: exp_lat});
    @(negedge clk);
    we = w; addr = a; wdata = wd; funct3 = f3; req_v[sel] = 1'b1;
    @(posedge clk);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      req_v[sel] = 1'b0;
      lat++;
      seen = ready_v[sel];
    end
    e = sb_q.pop_front();
    got_rd = rdata_v[sel];
    check({tag, ".ready"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, ".lat"}, 32'(lat), 32'(e.exp_lat));
      check({tag, ".err"}, 32'(err_v[sel]), 32'(e.exp_err));
      if (e.check_rdata) check({tag, ".rdata"}, rdata_v[sel], e.exp_rdata);
    end
    $display("[TB] %s dut%0d lat=%0d err=%0b rdata=0x%08h", tag, sel, lat, err_v[sel], rdata_v[sel]);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] c1;
    logic [31:0] c2;
    int          wc;
    int          wc1;

    tests = 0; fails = 0;
    we = 1'b0; addr = 32'h0; wdata = 32'h0; funct3 = 3'b000;
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.ready", 32'(ready_v[0]), 32'd0);
    check("rst.err", 32'(err_v[0]), 32'd0);
    check("rst.rdata", rdata_v[0], 32'h0);
    check("rst.leds", leds_v[0], 32'h0);
    check("rst.wr_ena", 32'(ram_wr_ena_v[0]), 32'd0);
    check("rst.byte_ena", 32'(ram_byte_ena_v[0]), 32'd0);
    rst = 1'b1;

    access(0, "sw_10", 1'b1, FUNCT3_SW, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 2, rd);
    check("sw_10.be", 32'(last_be[0]), 32'h0000_000F);
    check("sw_10.waddr", 32'(last_wa[0]), 32'd4);
    check("sw_10.wdata", last_wd[0], 32'hDEAD_BEEF);
    check("sw_10.wcnt", 32'(wr_cnt[0]), 32'd1);
    access(0, "lw_10", 1'b0, FUNCT3_LW, 32'h10, $urandom, 32'hDEAD_BEEF, 1'b1, 1'b0, 3, rd);
    check("lw_10.raddr", 32'(ram_addr_v[0]), 32'd4);

    access(0, "sb_13", 1'b1, FUNCT3_SB, 32'h13, 32'h0000_0080, 32'hDEAD_BEEF, 1'b1, 1'b0, 2, rd);
    check("sb_13.be", 32'(last_be[0]), 32'h0000_0008);
    check("sb_13.wdata", last_wd[0], 32'h8080_8080);
    access(0, "lb_13", 1'b0, FUNCT3_LB, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b0, 3, rd);
    access(0, "lbu_13", 1'b0, FUNCT3_LBU, 32'h13, 32'h0, 32'h0000_0080, 1'b1, 1'b0, 3, rd);

    access(0, "sh_12", 1'b1, FUNCT3_SH, 32'h12, 32'hABCD_1234, 32'h0000_0080, 1'b1, 1'b0, 2, rd);
    check("sh_12.be", 32'(last_be[0]), 32'h0000_000C);
    check("sh_12.wdata", last_wd[0], 32'h1234_1234);
    access(0, "lhu_12", 1'b0, FUNCT3_LHU, 32'h12, 32'h0, 32'h0000_1234, 1'b1, 1'b0, 3, rd);
    access(0, "lh_10", 1'b0, FUNCT3_LH, 32'h10, 32'h0, 32'hFFFF_BEEF, 1'b1, 1'b0, 3, rd);
    access(0, "lbu_11", 1'b0, FUNCT3_LBU, 32'h11, 32'h0, 32'h0000_00BE, 1'b1, 1'b0, 3, rd);
    access(0, "lw_alias", 1'b0, FUNCT3_LW, 32'h1010, 32'h0, 32'h1234_BEEF, 1'b1, 1'b0, 3, rd);

    wc = wr_cnt[0];
    access(0, "lh_11_mis", 1'b0, FUNCT3_LH, 32'h11, 32'h0, 32'h0, 1'b1, 1'b1, 1, rd);
    access(0, "sw_12_mis", 1'b1, FUNCT3_SW, 32'h12, 32'h5555_AAAA, 32'h0, 1'b1, 1'b1, 1, rd);
    access(0, "f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1, 1, rd);
    access(0, "st_f3_100", 1'b1, 3'b100, 32'h10, 32'h1, 32'h0, 1'b1, 1'b1, 1, rd);
    check("err.wcnt", 32'(wr_cnt[0]), 32'(wc));

    access(0, "sw_leds", 1'b1, FUNCT3_SW, 32'hF000_0000, 32'h5, 32'h0, 1'b1, 1'b0, 2, rd);
    check("sw_leds.leds", leds_v[0], 32'h5);
    access(0, "lw_leds", 1'b0, FUNCT3_LW, 32'hF000_0000, 32'h0, 32'h5, 1'b1, 1'b0, 2, rd);
    access(0, "sb_leds", 1'b1, FUNCT3_SB, 32'hF000_0000, 32'hFF, 32'h0, 1'b1, 1'b1, 1, rd);
    check("sb_leds.leds", leds_v[0], 32'h5);
    access(0, "lbu_leds", 1'b0, FUNCT3_LBU, 32'hF000_0000, 32'h0, 32'h5, 1'b1, 1'b0, 2, rd);
    access(0, "sw_cyc", 1'b1, FUNCT3_SW, 32'hF000_0004, 32'h123, 32'h5, 1'b1, 1'b0, 2, rd);
    access(0, "lw_cyc1", 1'b0, FUNCT3_LW, 32'hF000_0004, 32'h0, 32'h0, 1'b0, 1'b0, 2, c1);
    access(0, "lw_cyc2", 1'b0, FUNCT3_LW, 32'hF000_0004, 32'h0, 32'h0, 1'b0, 1'b0, 2, c2);
    check("cyc.incr", 32'(c2 > c1), 32'd1);
    check("cyc.small_step", 32'((c2 - c1) < 32'd16), 32'd1);
    access(0, "lw_mmio8", 1'b0, FUNCT3_LW, 32'hF000_0008, 32'h0, 32'h0, 1'b1, 1'b0, 2, rd);
    access(0, "sw_mmio10", 1'b1, FUNCT3_SW, 32'hF000_0010, 32'h77, 32'h0, 1'b1, 1'b0, 2, rd);
    check("mmio.leds", leds_v[0], 32'h5);
    check("mmio.wcnt", 32'(wr_cnt[0]), 32'(wc));

    access(1, "sw_20_l3", 1'b1, FUNCT3_SW, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b1, 1'b0, 2, rd);
    access(1, "lw_20_l3", 1'b0, FUNCT3_LW, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0, 5, rd);

    wc1 = wr_cnt[1];
    @(negedge clk);
    we = 1'b0; addr = 32'h20; funct3 = FUNCT3_LW; req_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_v[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst.ready", 32'(ready_v[1]), 32'd0);
    check("midrst.rdata", rdata_v[1], 32'h0);
    check("midrst.err", 32'(err_v[1]), 32'd0);
    check("midrst.wr_ena", 32'(ram_wr_ena_v[1]), 32'd0);
    check("midrst.leds", leds_v[0], 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst.ready_hold", 32'(ready_v[1]), 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst.ready_idle", 32'(ready_v[1]), 32'd0);
    end
    check("midrst.wcnt", 32'(wr_cnt[1]), 32'(wc1));
    $display("[TB] reset during load wait dut1 ready=%0b rdata=0x%08h", ready_v[1], rdata_v[1]);
    access(1, "lw_20_after_rst", 1'b0, FUNCT3_LW, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0, 5, rd);
    access(0, "lw_10_after_rst", 1'b0, FUNCT3_LW, 32'h10, 32'h0, 32'h1234_BEEF, 1'b1, 1'b0, 3, rd);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
